// File: rtl/act_arbiter.sv
// Round-robin arbiter in front of one shared Q8.8 activation unit (LReLU, sigmoid-3, tanh-5, pass).
// Define ACT_ARB_SATCNT_EN to build the saturation-event counter; otherwise sat_cnt reads 0.
module act_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      in_valid,
    output logic [N_REQ-1:0]      in_ready,
    input  logic [N_REQ*16-1:0]   in_x,
    input  logic [N_REQ*2-1:0]    in_func,
    input  logic                  cfg_we,
    input  logic [15:0]           cfg_alpha,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    output logic [15:0]           sat_cnt,
    input  logic                  sat_clr
);

    typedef enum logic [1:0] {
        FN_LRELU = 2'd0,
        FN_SIG3  = 2'd1,
        FN_TANH5 = 2'd2,
        FN_PASS  = 2'd3
    } func_e;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     gid;
    logic [ID_W-1:0]     ptr_next;
    logic                found;
    logic                issue;
    logic                accept;
    logic signed [15:0]  alpha_q;
    logic signed [15:0]  sel_x;
    func_e               sel_f;
    logic signed [31:0]  prod;
    logic signed [15:0]  sig_t;
    logic signed [15:0]  tanh_lo;
    logic signed [15:0]  tanh_hi;
    logic signed [15:0]  act_y;
    logic                sat_hit;
    logic                sat_event;

    assign issue  = !rst && (!out_valid || out_ready);
    assign accept = issue && found;

    // Two passes give the rotated search without a modulo: first ids at or
    // above ptr, then wrap around to the ids below it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && issue && in_valid[i] && (ID_W'(i) >= ptr)) begin
                found = 1'b1;
                gid   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && issue && in_valid[i] && (ID_W'(i) < ptr)) begin
                found = 1'b1;
                gid   = ID_W'(i);
            end
        end
    end

    assign ptr_next = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + ID_W'(1);

    // Handshake depends only on in_valid and state, never on operand data.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            in_ready[i] = found && (gid == ID_W'(i));
        end
    end

    always_comb begin
        sel_x = '0;
        sel_f = FN_LRELU;
        for (int i = 0; i < N_REQ; i++) begin
            if (gid == ID_W'(i)) begin
                sel_x = in_x[i*16 +: 16];
                sel_f = func_e'(in_func[i*2 +: 2]);
            end
        end
    end

    assign prod    = 32'(alpha_q) * 32'(sel_x);
    assign sig_t   = (sel_x >>> 1) + 16'sd256;
    assign tanh_lo = ((sel_x <<< 1) + 16'sd64) >>> 2;
    assign tanh_hi = ((sel_x <<< 1) - 16'sd64) >>> 2;

    always_comb begin
        act_y   = sel_x;
        sat_hit = 1'b0;
        case (sel_f)
            FN_LRELU: begin
                if (sel_x > 16'sd0) act_y = sel_x;
                else                act_y = 16'(prod >>> 8);
            end
            FN_SIG3: begin
                if (sel_x > 16'sd512) begin
                    act_y   = 16'sd256;
                    sat_hit = 1'b1;
                end else if (sel_x < -16'sd512) begin
                    act_y   = 16'sd0;
                    sat_hit = 1'b1;
                end else begin
                    act_y = sig_t >>> 1;
                end
            end
            FN_TANH5: begin
                if (sel_x >= 16'sd192) begin
                    act_y   = 16'sd256;
                    sat_hit = 1'b1;
                end else if (sel_x <= -16'sd192) begin
                    act_y   = -16'sd256;
                    sat_hit = 1'b1;
                end else if (sel_x < -16'sd64) begin
                    act_y = tanh_lo;
                end else if (sel_x > 16'sd64) begin
                    act_y = tanh_hi;
                end else begin
                    act_y = sel_x;
                end
            end
            default: act_y = sel_x;
        endcase
    end

    assign sat_event = accept && sat_hit;

    // The datapath reads alpha_q before this edge, so a same-edge cfg_we
    // only affects later requests.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
            alpha_q   <= 16'sh0019;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= act_y;
                out_id    <= gid;
                ptr       <= ptr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cfg_we) alpha_q <= cfg_alpha;
        end
    end

`ifdef ACT_ARB_SATCNT_EN
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_cnt <= '0;
        end else if (sat_event && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^{sat_clr, sat_event};
    assign sat_cnt    = '0;
`endif

endmodule

// File: doc/act_arbiter.md
ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter ID_W, default 2, meaning the requester-ID width, equal to clog2(N_REQ).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, N_REQ, the per-requester request valid.
REQ-006 The block SHALL have port in_ready, output, N_REQ, the per-requester accept.
REQ-007 The block SHALL have port in_x, input, N_REQ*16, the per-requester signed Q8.8 operand (requester i in bits [16i+15:16i]).
REQ-008 The block SHALL have port in_func, input, N_REQ*2, the per-requester function select: 0 LReLU, 1 sigmoid-3, 2 tanh-5, 3 passthrough.
REQ-009 The block SHALL have port cfg_we, input, 1, the alpha write strobe.
REQ-010 The block SHALL have port cfg_alpha, input, 16, the signed Q8.8 LReLU slope.
REQ-011 The block SHALL have port out_valid, output, 1, result valid.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-013 The block SHALL have port out_data, output, 16, the signed Q8.8 result.
REQ-014 The block SHALL have port out_id, output, ID_W, the requester index of out_data.
REQ-015 The block SHALL have ports sat_cnt, output, 16, the saturation-event count, and sat_clr, input, 1, which clears it.

Function
REQ-016 The block SHALL own one shared activation datapath; at most one request is accepted per cycle.
REQ-017 Issue is allowed when the output register can load: out_valid==0 or out_ready==1.
REQ-018 With issue allowed, the block SHALL grant the first i with in_valid[i]==1, searching round-robin from ptr; in_ready is one-hot on the granted i, else all zero.
REQ-019 in_ready SHALL depend on in_valid but SHALL NOT depend combinationally on any in_x or in_func.
REQ-020 On accept of requester g, ptr SHALL become (g+1) mod N_REQ; with no accept, ptr holds.
REQ-021 Latency SHALL be 1 cycle: accept at edge t means out_valid=1 with the result after edge t.
REQ-022 out_valid SHALL clear when out_ready==1 and no accept occurs; while out_valid==1 and out_ready==0, out_data and out_id SHALL hold.
REQ-023 LReLU: y = x when x>0, else (alpha*x)>>>8, using a 32-bit signed product truncated to its low 16 bits.
REQ-024 Sigmoid-3: y = 256 when x>512; 0 when x<-512; else ((x>>>1)+256)>>>1.
REQ-025 Tanh-5: y = 256 when x>=192; -256 when x<=-192; ((x<<<1)+64)>>>2 when -192<x<-64; ((x<<<1)-64)>>>2 when 64<x<192; else x.
REQ-026 Passthrough: y = x.
REQ-027 The alpha register SHALL load cfg_alpha at an edge with cfg_we==1; a request accepted at that same edge uses the old alpha.
REQ-028 A saturation event is an accepted sigmoid-3 request that hits a clamp branch, or an accepted tanh-5 request that hits a clamp branch.

Reset
REQ-029 On rst, out_valid, out_data, out_id, ptr and sat_cnt SHALL clear to 0; alpha SHALL reset to 0x0019 (about 0.1).
REQ-030 in_ready SHALL be all zero while rst==1; a result pending at reset SHALL be discarded.

Configuration
REQ-031 With macro ACT_ARB_SATCNT_EN defined, sat_cnt SHALL increment by 1 per saturation event, saturate at 0xFFFF, and clear on sat_clr; sat_clr takes priority over a same-cycle increment.
REQ-032 Without ACT_ARB_SATCNT_EN, sat_cnt SHALL be constant 0 and sat_clr SHALL be ignored; all other behaviour is identical.

Verification
REQ-033 The bench SHALL cover: after reset, req0 func=1 x=0 -> next cycle out_valid=1, out_data=128, out_id=0.
REQ-034 The bench SHALL cover: default alpha, req2 func=0 x=-256 (0xFF00) -> out_data=-25 (0xFFE7), out_id=2; then cfg_we alpha=0x0080 and repeat -> out_data=-128.
REQ-035 The bench SHALL cover: all four in_valid held high, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles, one accept per cycle.
REQ-036 The bench SHALL cover: out_ready=0 for 3 cycles with all in_valid high -> in_ready=0, out_data and out_id stable, no result lost or duplicated after release.
REQ-037 The bench SHALL cover: tanh x=128 -> 48; x=300 -> 256; x=-300 -> -256; with ACT_ARB_SATCNT_EN, sat_cnt=2, and sat_clr returns it to 0.
REQ-038 The bench SHALL cover: rst asserted while out_valid==1 and out_ready==0 -> the next cycle has out_valid=0 and ptr=0, so the first grant goes to requester 0.
